cmul_arbiter: RTL
=================

CMUL_ARBITER -- requirements
Module: cmul_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width, signed two's complement, per real/imag component.
REQ-002 Parameter LAT, default 6, legal range 1..16: fixed latency of the shared complex multiplier in cycles, from mul_en to mul_p_re/mul_p_im.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port flush, input, 1: synchronous clear of in-flight tags; active-high.
REQ-006 Ports req0_valid / req1_valid, input, 1 each: requester n offers an operand set.
REQ-007 Ports req0_ready / req1_ready, output, 1 each: grant; combinational from the valids and the priority pointer.
REQ-008 Ports reqN_a_re, reqN_a_im, reqN_w_re, reqN_w_im, input, WIDTH each: sample and twiddle operands for requester N (N=0,1).
REQ-009 Port mul_en, output, 1: registered valid strobe to the shared multiplier.
REQ-010 Ports mul_a_re, mul_a_im, mul_w_re, mul_w_im, output, WIDTH each: registered operands to the multiplier.
REQ-011 Ports mul_p_re, mul_p_im, input, WIDTH each: scaled multiplier product, valid exactly LAT cycles after the matching mul_en.
REQ-012 Ports rsp0_valid / rsp1_valid, output, 1 each: result for requester N is present this cycle; never both high.
REQ-013 Ports rsp_re, rsp_im, output, WIDTH each: shared registered result data.
REQ-014 Port outstanding, output, 5: number of issued operations whose response has not yet been returned (0..LAT+1).

Function
REQ-015 A handshake on requester N occurs in a cycle where reqN_valid and reqN_ready are both high; at most one handshake per cycle.
REQ-016 Only reqN_valid high: reqN_ready = 1; both valid: ready goes to the requester selected by the priority pointer ptr; neither valid: both readies 0.
REQ-017 ptr, 1 bit, selects req0 when 0; after any handshake, ptr <= ID of the non-granted requester (strict alternation under contention); ptr holds when there is no handshake.
REQ-018 Ready does not depend on any downstream backpressure; the multiplier is fully pipelined, so one issue per cycle is always accepted.
REQ-019 Issue stage: on a handshake, the next edge loads mul_a_*/mul_w_* from the granted requester's operands and sets mul_en = 1; with no handshake, mul_en <= 0 and the operands hold their values.
REQ-020 Tag pipeline: a shift register LAT entries deep of {valid, id}; entry 0 is loaded with {mul_en, issued id} on the same edge that mul_en is registered, and the entries advance one stage per cycle.
REQ-021 When the tag exits the pipeline (LAT cycles after mul_en), the next edge registers rsp_re <= mul_p_re, rsp_im <= mul_p_im, and sets rspID_valid = 1 for the tagged id, with all other rsp valids 0.
REQ-022 End-to-end latency: handshake in cycle t gives rspN_valid in cycle t+LAT+2; responses return in handshake order; throughput is 1 per cycle.
REQ-023 When no tag exits, both rsp valids are 0 and rsp_re/rsp_im hold their values.
REQ-024 outstanding increments on each handshake and decrements on each rsp valid; a simultaneous increment and decrement leaves it unchanged; it never wraps.
REQ-025 flush: the next edge clears mul_en, all tag valids, both rsp valids and outstanding to 0. Operands, rsp data and ptr hold. A handshake in the flush cycle is discarded; products already in the multiplier are ignored.
REQ-026 No overflow or rounding is done here; product scaling is the responsibility of the multiplier wrapper, and data is passed bit-exact.

Reset
REQ-027 While rst_n = 0, asynchronously and independent of clk: mul_en = 0, all mul operands = 0, tag pipeline cleared, rsp0_valid = rsp1_valid = 0, rsp_re = rsp_im = 0, outstanding = 0, ptr = 0.
REQ-028 While rst_n = 0, req0_ready and req1_ready are forced to 0. Reset asserted mid-operation drops all in-flight operations with no responses. The first handshake is possible on the first edge after rst_n deasserts.

Verification
REQ-029 Single request: LAT=6, req0 issues a=(100,-50), w=(16384,0) with the model multiplier output (a*w)>>14 -> rsp0_valid exactly 8 cycles later, rsp=(100,-50), outstanding returns to 0.
REQ-030 Contention: both valids held high for 6 cycles from reset -> grant sequence 0,1,0,1,0,1; responses return in that order on consecutive cycles; rsp0 and rsp1 never high together.
REQ-031 Single-source streaming: req1 valid for 20 cycles -> 20 consecutive handshakes; outstanding saturates at LAT+1=7, then falls 7..0 after the valid drops.
REQ-032 Flush: 4 operations in flight, flush pulsed for 1 cycle -> no rsp valid afterwards, outstanding = 0; a new request after the flush responds normally with latency LAT+2.
REQ-033 Reset mid-stream: rst_n low asynchronously between edges with 5 in flight -> all outputs 0 immediately; after release, a req1-only request is granted with ptr = 0 behaviour.
REQ-034 Parameter sweep LAT = 1 and LAT = 16 with a random valid pattern -> scoreboard matches every response id/data, and latency is LAT+2.

Source files
------------

// File: rtl/cmul_arbiter_if.sv
// rtl/cmul_arbiter_if.sv - requester, multiplier and response signals of the shared complex multiplier arbiter
interface cmul_arbiter_if #(parameter int WIDTH = 16);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a_re;
    logic [WIDTH-1:0] req0_a_im;
    logic [WIDTH-1:0] req0_w_re;
    logic [WIDTH-1:0] req0_w_im;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a_re;
    logic [WIDTH-1:0] req1_a_im;
    logic [WIDTH-1:0] req1_w_re;
    logic [WIDTH-1:0] req1_w_im;
    logic             mul_en;
    logic [WIDTH-1:0] mul_a_re;
    logic [WIDTH-1:0] mul_a_im;
    logic [WIDTH-1:0] mul_w_re;
    logic [WIDTH-1:0] mul_w_im;
    logic [WIDTH-1:0] mul_p_re;
    logic [WIDTH-1:0] mul_p_im;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_re;
    logic [WIDTH-1:0] rsp_im;
    logic [4:0]       outstanding;

    modport slave (
        input  req0_valid, req0_a_re, req0_a_im, req0_w_re, req0_w_im,
        input  req1_valid, req1_a_re, req1_a_im, req1_w_re, req1_w_im,
        input  mul_p_re, mul_p_im,
        output req0_ready, req1_ready,
        output mul_en, mul_a_re, mul_a_im, mul_w_re, mul_w_im,
        output rsp0_valid, rsp1_valid, rsp_re, rsp_im, outstanding
    );

    modport master (
        output req0_valid, req0_a_re, req0_a_im, req0_w_re, req0_w_im,
        output req1_valid, req1_a_re, req1_a_im, req1_w_re, req1_w_im,
        output mul_p_re, mul_p_im,
        input  req0_ready, req1_ready,
        input  mul_en, mul_a_re, mul_a_im, mul_w_re, mul_w_im,
        input  rsp0_valid, rsp1_valid, rsp_re, rsp_im, outstanding
    );
endinterface

// File: rtl/cmul_arbiter.sv
// rtl/cmul_arbiter.sv - two-requester round-robin front end for a fixed-latency pipelined complex multiplier
module cmul_arbiter #(
    parameter int WIDTH = 16,
    parameter int LAT   = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cmul_arbiter_if.slave bus
);
    logic             ptr_q, ptr_d;
    logic             mul_en_q, mul_en_d;
    logic [WIDTH-1:0] mul_a_re_q, mul_a_re_d, mul_a_im_q, mul_a_im_d;
    logic [WIDTH-1:0] mul_w_re_q, mul_w_re_d, mul_w_im_q, mul_w_im_d;
    logic [LAT-1:0]   tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic             exit_v_q, exit_v_d, exit_id_q, exit_id_d;
    logic             rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    logic [WIDTH-1:0] rsp_re_q, rsp_re_d, rsp_im_q, rsp_im_d;
    logic [4:0]       out_q, out_d;
    logic             ready0, ready1, hs, issue, deliver;

    // Grants are purely combinational; reset masks them so nothing is accepted while held.
    always_comb begin
        ready0 = rst_n & bus.req0_valid & (~bus.req1_valid | ~ptr_q);
        ready1 = rst_n & bus.req1_valid & (~bus.req0_valid | ptr_q);
        hs      = ready0 | ready1;
        issue   = hs & ~flush;
        deliver = exit_v_q & ~flush;
    end

    always_comb begin
        ptr_d      = ptr_q;
        mul_en_d   = issue;
        mul_a_re_d = mul_a_re_q;
        mul_a_im_d = mul_a_im_q;
        mul_w_re_d = mul_w_re_q;
        mul_w_im_d = mul_w_im_q;
        if (issue) begin
            ptr_d      = ~ready1;
            mul_a_re_d = ready1 ? bus.req1_a_re : bus.req0_a_re;
            mul_a_im_d = ready1 ? bus.req1_a_im : bus.req0_a_im;
            mul_w_re_d = ready1 ? bus.req1_w_re : bus.req0_w_re;
            mul_w_im_d = ready1 ? bus.req1_w_im : bus.req0_w_im;
        end
    end

    // Tag shift register tracks which requester owns each product; the exit stage
    // lines the tag up with the cycle the matching product appears on mul_p_*.
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = issue;
        tag_id_d[0] = ready1;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1] & ~flush;
            tag_id_d[i] = tag_id_q[i-1];
        end
        exit_v_d  = tag_v_q[LAT-1] & ~flush;
        exit_id_d = tag_id_q[LAT-1];
    end

    always_comb begin
        rsp0_d   = deliver & ~exit_id_q;
        rsp1_d   = deliver & exit_id_q;
        rsp_re_d = deliver ? bus.mul_p_re : rsp_re_q;
        rsp_im_d = deliver ? bus.mul_p_im : rsp_im_q;
        if (flush)
            out_d = 5'd0;
        else
            out_d = out_q + {4'd0, issue} - {4'd0, deliver};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= 1'b0;
            mul_en_q   <= 1'b0;
            mul_a_re_q <= '0;
            mul_a_im_q <= '0;
            mul_w_re_q <= '0;
            mul_w_im_q <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            exit_v_q   <= 1'b0;
            exit_id_q  <= 1'b0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rsp_re_q   <= '0;
            rsp_im_q   <= '0;
            out_q      <= 5'd0;
        end else begin
            ptr_q      <= ptr_d;
            mul_en_q   <= mul_en_d;
            mul_a_re_q <= mul_a_re_d;
            mul_a_im_q <= mul_a_im_d;
            mul_w_re_q <= mul_w_re_d;
            mul_w_im_q <= mul_w_im_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            exit_v_q   <= exit_v_d;
            exit_id_q  <= exit_id_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            rsp_re_q   <= rsp_re_d;
            rsp_im_q   <= rsp_im_d;
            out_q      <= out_d;
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.mul_en      = mul_en_q;
    assign bus.mul_a_re    = mul_a_re_q;
    assign bus.mul_a_im    = mul_a_im_q;
    assign bus.mul_w_re    = mul_w_re_q;
    assign bus.mul_w_im    = mul_w_im_q;
    assign bus.rsp0_valid  = rsp0_q;
    assign bus.rsp1_valid  = rsp1_q;
    assign bus.rsp_re      = rsp_re_q;
    assign bus.rsp_im      = rsp_im_q;
    assign bus.outstanding = out_q;
endmodule
